// File: rtl/spi_slave_byte.sv
// spi_slave_byte: byte-oriented SPI slave (CPHA=0, CPOL parameterised) that
// oversamples sclk/n_cs/mosi in the clk domain and moves bytes between the
// SPI master and a pair of 8-bit FIFOs (show-ahead TX, plain RX).
//
// Optional feature: define SPI_SLAVE_ERR_FLAGS_EN to get sticky ovf/udf error
// flags cleared by err_clr. Without it ovf/udf read 0 and err_clr is ignored.
//
// Ports:
//   clk, n_rst          system clock, async active-low reset
//   sclk, n_cs, mosi    SPI pins from the master (asynchronous to clk)
//   miso, miso_oe       serial data out and its pad output enable
//   tx_empty, tx_data   TX FIFO status and show-ahead head word
//   tx_rdreq            TX FIFO pop, asserted in the cycle a byte is loaded
//   rx_full             RX FIFO status
//   rx_data, rx_wrreq   RX FIFO write data and strobe
//   busy                high while a transfer is in progress
//   ovf, udf, err_clr   sticky RX overrun / TX underrun flags and their clear
module spi_slave_byte #(
  parameter bit         CPOL = 1'b0,
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sclk,
  input  logic       n_cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       tx_empty,
  input  logic [7:0] tx_data,
  output logic       tx_rdreq,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       rx_wrreq,
  output logic       busy,
  output logic       ovf,
  output logic       udf,
  input  logic       err_clr
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   bit_cnt, bit_cnt_n;
  logic [DW-1:0]   tx_sr, tx_sr_n;
  logic [DW-1:0]   rx_sr, rx_sr_n;
  logic [DW-1:0]   rx_data_n;
  logic            rx_wrreq_n;
  logic            tx_load;
  logic            ovf_set, udf_set;

  // Synchronizers plus history registers
  logic sclk_s1, sclk_s2, sclk_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2, mosi_h;
  logic [1:0] sync_vld;
  logic cs_arm;

  // Registered one-clk event pulses
  logic lead_q, trail_q, cs_fall_q, cs_rise_q;

  // Pin synchronization and edge detection; mosi_h stays aligned with lead_q.
  // cs_arm blocks a cs_fall until n_cs has genuinely been seen high after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_s1   <= CPOL;
      sclk_s2   <= CPOL;
      sclk_h    <= CPOL;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_h      <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      mosi_h    <= 1'b0;
      sync_vld  <= 2'b00;
      cs_arm    <= 1'b0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_h    <= sclk_s2;
      cs_s1     <= n_cs;
      cs_s2     <= cs_s1;
      cs_h      <= cs_s2;
      mosi_s1   <= mosi;
      mosi_s2   <= mosi_s1;
      mosi_h    <= mosi_s2;
      sync_vld  <= {sync_vld[0], 1'b1};
      cs_arm    <= cs_arm | (sync_vld[1] & cs_s2);
      lead_q    <= (sclk_h == CPOL) && (sclk_s2 != CPOL);
      trail_q   <= (sclk_h != CPOL) && (sclk_s2 == CPOL);
      cs_fall_q <= cs_arm & cs_h & ~cs_s2;
      cs_rise_q <= ~cs_h & cs_s2;
      miso_oe   <= ~cs_s2;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_wrreq <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      tx_sr    <= tx_sr_n;
      rx_sr    <= rx_sr_n;
      rx_data  <= rx_data_n;
      rx_wrreq <= rx_wrreq_n;
    end
  end

  // Next-state and datapath control; cs_rise has priority over sclk edges
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    rx_data_n  = rx_data;
    rx_wrreq_n = 1'b0;
    tx_load    = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall_q) begin
          state_n   = ACTIVE;
          bit_cnt_n = '0;
          tx_load   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise_q) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
        end else if (lead_q) begin
          rx_sr_n   = {rx_sr[DW-2:0], mosi_h};
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(7)) begin
            if (!rx_full) begin
              rx_data_n  = rx_sr_n;
              rx_wrreq_n = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end
        end else if (trail_q) begin
          if (bit_cnt == '0) tx_load = 1'b1;
          else               tx_sr_n = {tx_sr[DW-2:0], 1'b0};
        end
      end
      default: state_n = IDLE;
    endcase
    // Byte boundary load from the show-ahead head, or FILL when empty
    tx_rdreq = tx_load & ~tx_empty;
    udf_set  = tx_load & tx_empty;
    if (tx_load) tx_sr_n = tx_empty ? FILL : tx_data;
  end

  assign miso = tx_sr[DW-1];
  assign busy = (state == ACTIVE);

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  // Sticky error flags; a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
  logic unused_flags;
  assign unused_flags = &{1'b0, ovf_set, udf_set, err_clr};
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Testbench for spi_slave_byte: a CPOL=0 and a CPOL=1 instance run side by
// side (the CPOL=1 instance sees the inverted sclk), fed by a TX FIFO model
// and logging RX writes.
module tb_spi_slave_byte;

  localparam int unsigned H = 8;

  logic clk = 1'b0;
  logic n_rst, sclk, n_cs, mosi, rx_full, err_clr;
  logic sclk1;
  logic tx_empty;
  logic [7:0] tx_data;

  logic miso0, miso_oe0, tx_rdreq0, rx_wrreq0, busy0, ovf0, udf0;
  logic miso1, miso_oe1, tx_rdreq1, rx_wrreq1, busy1, ovf1, udf1;
  logic [7:0] rx_data0, rx_data1;

  assign sclk1 = ~sclk;
  always #5 clk = ~clk;

  spi_slave_byte #(.CPOL(1'b0), .FILL(8'hFF)) dut0 (
    .clk(clk), .n_rst(n_rst), .sclk(sclk), .n_cs(n_cs), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_rdreq(tx_rdreq0), .rx_full(rx_full), .rx_data(rx_data0),
    .rx_wrreq(rx_wrreq0), .busy(busy0), .ovf(ovf0), .udf(udf0), .err_clr(err_clr)
  );

  spi_slave_byte #(.CPOL(1'b1), .FILL(8'hFF)) dut1 (
    .clk(clk), .n_rst(n_rst), .sclk(sclk1), .n_cs(n_cs), .mosi(mosi),
    .miso(miso1), .miso_oe(miso_oe1), .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_rdreq(tx_rdreq1), .rx_full(rx_full), .rx_data(rx_data1),
    .rx_wrreq(rx_wrreq1), .busy(busy1), .ovf(ovf1), .udf(udf1), .err_clr(err_clr)
  );

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  // TX FIFO model (popped by dut0) and RX logs for both instances
  logic [7:0] tx_mem [0:63];
  int tx_wr = 0, tx_rd = 0;
  int rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0;
  logic [7:0] rx_log0 [0:63];
  logic [7:0] rx_log1 [0:63];

  assign tx_empty = (tx_rd == tx_wr);
  assign tx_data  = tx_mem[tx_rd[5:0]];

  always @(posedge clk) begin
    if (tx_rdreq0) begin
      tx_rd <= tx_rd + 1;
      rd0   <= rd0 + 1;
    end
    if (tx_rdreq1) rd1 <= rd1 + 1;
    if (rx_wrreq0) begin
      rx_log0[wr0[5:0]] <= rx_data0;
      wr0 <= wr0 + 1;
    end
    if (rx_wrreq1) begin
      rx_log1[wr1[5:0]] <= rx_data1;
      wr1 <= wr1 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    tx_mem[tx_wr[5:0]] = b;
    tx_wr++;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
  endtask

  // Master: set mosi, sample miso just before the leading edge, then trail
  task automatic shift_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi0, output logic [7:0] mi1);
    mi0 = '0;
    mi1 = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(H);
      mi0 = {mi0[6:0], miso0};
      mi1 = {mi1[6:0], miso1};
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
  endtask

  typedef struct {
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    int         exp_rd;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] m0, m1;
  int b_rd0, b_rd1, b_wr0, b_wr1;

  task automatic snap();
    b_rd0 = rd0; b_rd1 = rd1; b_wr0 = wr0; b_wr1 = wr1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 0};
    vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h81, 1};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};

    n_rst = 1'b0; n_cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx_full = 1'b0; err_clr = 1'b0;
    wait_clk(3);
    check("reset_outs0", {miso0, miso_oe0, tx_rdreq0, rx_wrreq0, busy0, ovf0, udf0, rx_data0}, 0);
    check("reset_outs1", {miso1, miso_oe1, tx_rdreq1, rx_wrreq1, busy1, ovf1, udf1, rx_data1}, 0);
    n_rst = 1'b1;
    wait_clk(2*H);

    // Single-byte transfers from the vector table
    for (int v = 0; v < 4; v++) begin
      snap();
      if (vecs[v].tx_valid) push(vecs[v].tx_byte);
      pulse_clr();
      n_cs = 1'b0;
      wait_clk(H);
      check($sformatf("v%0d_busy", v), {busy0, busy1, miso_oe0, miso_oe1}, 4'hF);
      check($sformatf("v%0d_udf_load", v), udf0, vecs[v].tx_valid ? 1'b0 : EXP_FLAG);
      shift_bits(vecs[v].mo, 8, m0, m1);
      wait_clk(H);
      n_cs = 1'b1;
      wait_clk(2*H);
      check($sformatf("v%0d_miso0", v), m0, vecs[v].exp_miso);
      check($sformatf("v%0d_miso1", v), m1, vecs[v].exp_miso);
      check($sformatf("v%0d_rdreq", v), {rd0 - b_rd0, rd1 - b_rd1}, {vecs[v].exp_rd, vecs[v].exp_rd});
      check($sformatf("v%0d_wrreq", v), {wr0 - b_wr0, wr1 - b_wr1}, {32'd1, 32'd1});
      check($sformatf("v%0d_rx0", v), rx_log0[b_wr0[5:0]], vecs[v].mo);
      check($sformatf("v%0d_rx1", v), rx_log1[b_wr1[5:0]], vecs[v].mo);
      check($sformatf("v%0d_idle", v), {busy0, busy1, miso_oe0}, 3'b000);
    end

    // Three-byte burst with n_cs held low
    snap();
    push(8'h01); push(8'h02); push(8'h03);
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'h10, 8, m0, m1);
    check("burst_tx0", {m0, m1}, 16'h0101);
    shift_bits(8'h20, 8, m0, m1);
    check("burst_tx1", {m0, m1}, 16'h0202);
    shift_bits(8'h30, 8, m0, m1);
    check("burst_tx2", {m0, m1}, 16'h0303);
    wait_clk(H);
    n_cs = 1'b1;
    wait_clk(2*H);
    check("burst_rdreq", {rd0 - b_rd0, rd1 - b_rd1}, {32'd3, 32'd3});
    check("burst_wrreq", {wr0 - b_wr0, wr1 - b_wr1}, {32'd2 + 32'd1, 32'd3});
    check("burst_rx0", {rx_log0[b_wr0[5:0]], rx_log0[6'(b_wr0 + 1)], rx_log0[6'(b_wr0 + 2)]}, 24'h102030);
    check("burst_rx1", {rx_log1[b_wr1[5:0]], rx_log1[6'(b_wr1 + 1)], rx_log1[6'(b_wr1 + 2)]}, 24'h102030);

    // RX FIFO full during the second byte
    snap();
    pulse_clr();
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'h55, 8, m0, m1);
    check("ovf_before_full", ovf0, 1'b0);
    rx_full = 1'b1;
    shift_bits(8'hAA, 8, m0, m1);
    rx_full = 1'b0;
    wait_clk(H);
    n_cs = 1'b1;
    wait_clk(2*H);
    check("full_wrreq", {wr0 - b_wr0, wr1 - b_wr1}, {32'd1, 32'd1});
    check("full_rx", {rx_log0[b_wr0[5:0]], rx_log1[b_wr1[5:0]]}, 16'h5555);
    check("ovf_set", {ovf0, ovf1}, {EXP_FLAG, EXP_FLAG});
    pulse_clr();
    check("ovf_clr", {ovf0, ovf1, udf0, udf1}, 4'h0);

    // n_cs rises after 5 bits, then a full byte
    snap();
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'hF0, 5, m0, m1);
    wait_clk(H);
    n_cs = 1'b1;
    wait_clk(2*H);
    check("partial_nowr", {wr0 - b_wr0, wr1 - b_wr1}, {32'd0, 32'd0});
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'hC3, 8, m0, m1);
    wait_clk(H);
    n_cs = 1'b1;
    wait_clk(2*H);
    check("partial_wr", {wr0 - b_wr0, wr1 - b_wr1}, {32'd1, 32'd1});
    check("partial_rx", {rx_log0[b_wr0[5:0]], rx_log1[b_wr1[5:0]]}, 16'hC3C3);
    check("partial_miso", {m0, m1}, 16'hFFFF);

    // Reset mid-byte, n_cs still low after release, then a clean transfer
    snap();
    push(8'hA5);
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'h3C, 4, m0, m1);
    n_rst = 1'b0;
    wait_clk(1);
    check("midrst_outs0", {miso0, miso_oe0, tx_rdreq0, rx_wrreq0, busy0, ovf0, udf0, rx_data0}, 0);
    check("midrst_outs1", {miso1, miso_oe1, tx_rdreq1, rx_wrreq1, busy1, ovf1, udf1, rx_data1}, 0);
    wait_clk(2);
    n_rst = 1'b1;
    wait_clk(2*H);
    shift_bits(8'hFF, 4, m0, m1);
    check("rst_cs_low_idle", {busy0, busy1}, 2'b00);
    check("rst_cs_low_nowr", {wr0 - b_wr0, wr1 - b_wr1}, {32'd0, 32'd0});
    n_cs = 1'b1;
    wait_clk(2*H);
    snap();
    push(8'hA5);
    n_cs = 1'b0;
    wait_clk(H);
    shift_bits(8'h3C, 8, m0, m1);
    wait_clk(H);
    n_cs = 1'b1;
    wait_clk(2*H);
    check("post_rst_miso", {m0, m1}, 16'hA5A5);
    check("post_rst_rdreq", {rd0 - b_rd0, rd1 - b_rd1}, {32'd1, 32'd1});
    check("post_rst_wr", {wr0 - b_wr0, wr1 - b_wr1}, {32'd1, 32'd1});
    check("post_rst_rx", {rx_log0[b_wr0[5:0]], rx_log1[b_wr1[5:0]]}, 16'h3C3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
